// File: rtl/convcor_peak_detect.sv
// Convcor peak detector: per input burst, finds the sample with the largest
// L1 magnitude |re|+|im| and emits a one-cycle summary after the burst ends.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      sample strobe; a burst is one contiguous high run
//   in_data       {re, im}, each DATA_W-bit two's complement
//   out_valid     one-cycle summary strobe
//   out_peak_mag  |re|+|im| of the peak sample (unsigned, DATA_W+1 bits)
//   out_peak_idx  0-based position of the peak within the burst
//   out_len       samples accepted (saturates at MAX_LEN)
//   out_peak_data raw in_data of the peak sample
//   out_err       burst ran longer than MAX_LEN samples
//   All out_* read 0 whenever out_valid is low.

module convcor_peak_detect #(
  parameter int DATA_W  = 18,
  parameter int MAX_LEN = 5,
  parameter int IDX_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                out_valid,
  output logic [DATA_W:0]     out_peak_mag,
  output logic [IDX_W-1:0]    out_peak_idx,
  output logic [IDX_W-1:0]    out_len,
  output logic [2*DATA_W-1:0] out_peak_data,
  output logic                out_err
);

  localparam logic [IDX_W-1:0] MaxLen = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] One    = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W:0]     pk_mag_q, pk_mag_d;
  logic [IDX_W-1:0]    pk_idx_q, pk_idx_d;
  logic [IDX_W-1:0]    len_q, len_d;
  logic [2*DATA_W-1:0] pk_data_q, pk_data_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0] re_raw, im_raw;
  logic [DATA_W-1:0] re_abs, im_abs;
  logic [DATA_W:0]   mag;
  logic              first;
  logic              room;

  // Magnitude of the incoming sample. Negating -2^(DATA_W-1) wraps back
  // to the same bit pattern, which read as unsigned is exactly 2^(DATA_W-1).
  assign re_raw = in_data[2*DATA_W-1:DATA_W];
  assign im_raw = in_data[DATA_W-1:0];

  assign re_abs = re_raw[DATA_W-1] ? (~re_raw) + DATA_W'(1) : re_raw;
  assign im_abs = im_raw[DATA_W-1] ? (~im_raw) + DATA_W'(1) : im_raw;

  assign mag = {1'b0, re_abs} + {1'b0, im_abs};

  // A sample opens a new burst from IDLE, and also from OUT so that a
  // single idle cycle between bursts is enough.
  assign first = in_valid && (state_q != ACC);
  assign room  = len_q < MaxLen;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = in_valid ? ACC : IDLE;
      ACC:  state_d = in_valid ? ACC : OUT;
      OUT:  state_d = in_valid ? ACC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Peak accumulator next-state
  always_comb begin
    pk_mag_d  = pk_mag_q;
    pk_idx_d  = pk_idx_q;
    len_d     = len_q;
    pk_data_d = pk_data_q;
    err_d     = err_q;
    unique case (1'b1)
      first: begin
        pk_mag_d  = mag;
        pk_idx_d  = '0;
        len_d     = One;
        pk_data_d = in_data;
        err_d     = 1'b0;
      end
      (state_q == ACC) && in_valid && room: begin
        // Strictly greater: ties keep the earlier index.
        if (mag > pk_mag_q) begin
          pk_mag_d  = mag;
          pk_idx_d  = len_q;
          pk_data_d = in_data;
        end
        len_d = len_q + One;
      end
      (state_q == ACC) && in_valid && !room: begin
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pk_mag_q  <= '0;
      pk_idx_q  <= '0;
      len_q     <= '0;
      pk_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pk_mag_q  <= pk_mag_d;
      pk_idx_q  <= pk_idx_d;
      len_q     <= len_d;
      pk_data_q <= pk_data_d;
      err_q     <= err_d;
    end
  end

  // Outputs: the accumulators stay frozen during OUT, so they double as
  // the summary word; everything is forced to 0 outside OUT.
  always_comb begin
    out_valid     = 1'b0;
    out_peak_mag  = '0;
    out_peak_idx  = '0;
    out_len       = '0;
    out_peak_data = '0;
    out_err       = 1'b0;
    if (state_q == OUT) begin
      out_valid     = 1'b1;
      out_peak_mag  = pk_mag_q;
      out_peak_idx  = pk_idx_q;
      out_len       = len_q;
      out_peak_data = pk_data_q;
      out_err       = err_q;
    end
  end

endmodule

// File: tb/tb_convcor_peak_detect.sv
// Testbench for convcor_peak_detect: directed bursts followed by random
// bursts, every cycle compared against a burst-level reference model.

module tb_convcor_peak_detect;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [35:0] in_data;
  logic        out_valid;
  logic [18:0] out_peak_mag;
  logic [2:0]  out_peak_idx;
  logic [2:0]  out_len;
  logic [35:0] out_peak_data;
  logic        out_err;

  convcor_peak_detect dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_peak_mag(out_peak_mag),
    .out_peak_idx(out_peak_idx),
    .out_len(out_len),
    .out_peak_data(out_peak_data),
    .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [35:0] burst[$];
  logic [35:0] stim[$];

  logic        exp_v;
  logic [18:0] exp_mag;
  logic [2:0]  exp_idx;
  logic [2:0]  exp_len;
  logic [35:0] exp_data;
  logic        exp_err;

  function automatic logic [35:0] cplx(input int re, input int im);
    logic [17:0] r, i;
    r = 18'(re);
    i = 18'(im);
    return {r, i};
  endfunction

  function automatic logic [18:0] l1(input logic [35:0] d);
    int re, im;
    re = int'($signed(d[35:18]));
    im = int'($signed(d[17:0]));
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    return 19'(re + im);
  endfunction

  task automatic clear_exp();
    exp_v    = 1'b0;
    exp_mag  = '0;
    exp_idx  = '0;
    exp_len  = '0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  // Summary of the completed burst held in 'burst'.
  task automatic summarize();
    int n, lim, best;
    n = burst.size();
    lim = (n > 5) ? 5 : n;
    best = 0;
    for (int i = 1; i < lim; i++)
      if (l1(burst[i]) > l1(burst[best])) best = i;
    exp_v    = 1'b1;
    exp_mag  = l1(burst[best]);
    exp_idx  = 3'(best);
    exp_len  = 3'(lim);
    exp_data = burst[best];
    exp_err  = (n > 5);
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(out_valid), 64'(exp_v));
    chk("mag", 64'(out_peak_mag), 64'(exp_mag));
    chk("idx", 64'(out_peak_idx), 64'(exp_idx));
    chk("len", 64'(out_len), 64'(exp_len));
    chk("data", 64'(out_peak_data), 64'(exp_data));
    chk("err", 64'(out_err), 64'(exp_err));
  endtask

  // One cycle: check outputs against the expectation set last cycle,
  // then drive new inputs and derive what the next cycle must show.
  task automatic cyc(input logic rn, input logic v, input logic [35:0] d);
    @(negedge clk);
    check_all();
    rst_n    = rn;
    in_valid = v;
    in_data  = v ? d : 'x;
    clear_exp();
    if (!rn) begin
      burst.delete();
    end else if (v) begin
      burst.push_back(d);
    end else if (burst.size() != 0) begin
      summarize();
      burst.delete();
    end
  endtask

  task automatic send(input int gap);
    foreach (stim[i]) cyc(1'b1, 1'b1, stim[i]);
    for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, '0);
  endtask

  function automatic logic [35:0] rnd_sample();
    if ($urandom_range(0, 2) == 0)
      return cplx($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
    return {$urandom(), 4'($urandom())};
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear_exp();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);

    // Single sample 3+4j
    stim = '{cplx(3, 4)};
    send(3);

    // Five samples, peak at index 3
    stim = '{cplx(10, 0), cplx(2, 0), cplx(-30, 0), cplx(40, 0), cplx(5, 0)};
    send(3);

    // Ties keep index 0
    stim = '{cplx(9, 0), cplx(0, 9), cplx(-4, -5)};
    send(2);

    // Extreme magnitude
    stim = '{cplx(-131072, -131072)};
    send(2);

    // Seven samples, largest one beyond MAX_LEN, then a clean burst
    stim = '{cplx(1, 1), cplx(2, 2), cplx(7, 0), cplx(3, 3), cplx(0, 4),
             cplx(100, 0), cplx(-200, 0)};
    send(2);
    stim = '{cplx(-6, 1)};
    send(2);

    // Reset mid-burst after two samples
    stim = '{cplx(50, 50), cplx(60, 60)};
    send(0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    stim = '{cplx(-8, 8), cplx(20, -1)};
    send(2);

    // Back-to-back bursts with a single idle cycle
    stim = '{cplx(1, 0), cplx(-2, 0), cplx(0, 3), cplx(0, -7), cplx(6, 0)};
    send(1);
    stim = '{cplx(-11, 2)};
    send(1);
    cyc(1'b1, 1'b0, '0);

    // Random bursts, gaps and occasional resets
    repeat (60) begin
      stim.delete();
      repeat ($urandom_range(1, 7)) stim.push_back(rnd_sample());
      if ($urandom_range(0, 9) == 0) begin
        send(0);
        cyc(1'b0, $urandom_range(0, 1) == 1, rnd_sample());
        cyc(1'b1, 1'b0, '0);
      end else begin
        send($urandom_range(1, 3));
      end
    end

    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
